// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite bus bundle between a bus master and ahb_sram_slave
//   master drives: hsel_i, haddr_i[31:0], hwdata_i[31:0], hsize_i[2:0], hwrite_i
//   slave drives:  hrdata_o[31:0], hready_o, hresp_o[1:0]
interface ahb_sram_if;
   logic        hsel_i;
   logic [31:0] haddr_i;
   logic [31:0] hwdata_i;
   logic [2:0]  hsize_i;
   logic        hwrite_i;
   logic [31:0] hrdata_o;
   logic        hready_o;
   logic [1:0]  hresp_o;
   modport master (output hsel_i, haddr_i, hwdata_i, hsize_i, hwrite_i, input hrdata_o, hready_o, hresp_o);
   modport slave (input hsel_i, haddr_i, hwdata_i, hsize_i, hwrite_i, output hrdata_o, hready_o, hresp_o);
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite single-port word SRAM with byte-lane writes and programmable wait states
//   clk_i     clock, all state on rising edge
//   resetn_i  asynchronous active-low reset
//   bus       ahb_sram_if.slave (hsel/haddr/hwdata/hsize/hwrite in, hrdata/hready/hresp out)
//   Optional: define AHB_SRAM_ERR_EN for two-cycle ERROR responses on out-of-range,
//   misaligned or oversized accesses; otherwise addresses wrap and hresp is always OKAY.
module ahb_sram_slave #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0
) (
   input logic       clk_i,
   input logic       resetn_i,
   ahb_sram_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);
   typedef enum logic [1:0] {IDLE, DATA, ERR_1, ERR_2} state_t;
   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic [AW-1:0]         idx_q;
   logic [3:0]            strb_q;
   logic                  wr_q;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [31:0]           off;
   logic [3:0]            strb;
   logic                  accept, done, illegal, unused_off;
   assign off        = bus.haddr_i - BASE_ADDR;
   assign unused_off = ^{off[31:AW+2], off[1:0]};
   assign accept     = bus.hsel_i && bus.hready_o;
   assign done       = state == DATA && cnt == 4'd0;
   // byte uses the exact lane, halfword only addr[1]; every other size is a full word
   assign strb = bus.hsize_i == 3'b000 ? 4'b0001 << bus.haddr_i[1:0]
               : bus.hsize_i == 3'b001 ? (bus.haddr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef AHB_SRAM_ERR_EN
   assign illegal = |off[31:AW+2] || bus.hsize_i[2] || bus.hsize_i == 3'b011
                 || (bus.hsize_i == 3'b001 && bus.haddr_i[0])
                 || (bus.hsize_i == 3'b010 && |bus.haddr_i[1:0]);
   assign bus.hresp_o = (state == ERR_1 || state == ERR_2) ? 2'b01 : 2'b00;
`else
   assign illegal     = 1'b0;
   assign bus.hresp_o = 2'b00;
`endif
   assign bus.hready_o = state == IDLE || state == ERR_2 || done;
   assign bus.hrdata_o = done && !wr_q ? mem[idx_q] : '0;
   always_comb begin
      state_nxt = accept ? (illegal ? ERR_1 : DATA) : bus.hready_o ? IDLE : state == ERR_1 ? ERR_2 : state;
   end
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state  <= IDLE;
         cnt    <= '0;
         idx_q  <= '0;
         strb_q <= '0;
         wr_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt    <= 4'(WAIT_STATES);
            idx_q  <= off[AW+1:2];
            strb_q <= strb;
            wr_q   <= bus.hwrite_i;
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end
   // commit happens on the edge closing the data phase, so a back-to-back read sees it
   always_ff @(posedge clk_i) begin
      if (done && wr_q)
         for (int i = 0; i < 4; i++)
            if (strb_q[i]) mem[idx_q][8*i +: 8] <= bus.hwdata_i[8*i +: 8];
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized and directed checks of ahb_sram_slave against a transfer-level model
module tb_ahb_sram_slave;
   localparam int          MW   = 16;
   localparam logic [31:0] BASE = 32'h40;
   localparam int          WS   = 2;
   logic clk = 0, resetn = 1;
   always #5 clk = ~clk;
   ahb_sram_if bus ();
   ahb_sram_slave #(.DATA_WIDTH(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_STATES(WS))
      dut (.clk_i(clk), .resetn_i(resetn), .bus(bus));
   int          tests = 0, fails = 0, cyc = 0, c0;
   logic [31:0] mm [MW];
   bit          ph_v, ph_err, ph_e2, ph_wr, acc, exp_rdy;
   int          ph_wait, ph_idx;
   logic [3:0]  ph_mask;
   logic [31:0] hold_wd, got_rd, ra;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // one bus cycle: drive, compare against the model, then advance the model
   task automatic step(bit sel, logic [31:0] a, logic [2:0] sz, bit wr);
      logic [31:0] off, exp_rd;
      bit          rd_done;
      @(posedge clk);
      #1;
      bus.hsel_i = sel; bus.haddr_i = a; bus.hsize_i = sz; bus.hwrite_i = wr; bus.hwdata_i = hold_wd;
      @(negedge clk);
      cyc++;
      exp_rdy = !ph_v || (ph_err ? ph_e2 : ph_wait == 0);
      rd_done = ph_v && !ph_err && !ph_wr && ph_wait == 0;
      exp_rd  = rd_done ? mm[ph_idx] : 32'h0;
      chk("hready", 32'(bus.hready_o), 32'(exp_rdy));
      chk("hresp", 32'(bus.hresp_o), (ph_v && ph_err) ? 32'd1 : 32'd0);
      chk("hrdata", bus.hrdata_o, exp_rd);
      if (rd_done) got_rd = bus.hrdata_o;
      acc = 0;
      if (!resetn) ph_v = 0;
      else if (exp_rdy) begin
         if (ph_v && !ph_err && ph_wr)
            for (int i = 0; i < 4; i++) if (ph_mask[i]) mm[ph_idx][8*i +: 8] = hold_wd[8*i +: 8];
         acc  = sel;
         ph_v = sel;
         if (sel) begin
            off     = a - BASE;
            ph_idx  = int'((off >> 2) % MW);
            ph_wr   = wr;
            ph_wait = WS;
            ph_e2   = 0;
            ph_mask = sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? 4'(3 << (a & 2)) : 4'hF;
`ifdef AHB_SRAM_ERR_EN
            ph_err = off >= MW * 4 || sz >= 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
`else
            ph_err = 0;
`endif
         end
      end else if (ph_err) ph_e2 = 1;
      else ph_wait--;
   endtask
   task automatic xfer(logic [31:0] a, logic [2:0] sz, bit wr, logic [31:0] d);
      int n = 0;
      do begin
         step(1, a, sz, wr);
         n++;
      end while (!acc && n < 20);
      chk("accept", 32'(acc), 32'd1);
      hold_wd = d;
   endtask
   task automatic drain();
      int n = 0;
      do begin
         step(0, 32'h0, 3'd0, 0);
         n++;
      end while (bus.hready_o !== 1'b1 && n < 20);
      chk("drain", 32'(bus.hready_o), 32'd1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end
   initial begin
      bus.hsel_i = 0; bus.haddr_i = 0; bus.hsize_i = 0; bus.hwrite_i = 0; bus.hwdata_i = 0;
      hold_wd = 0; got_rd = 0; ph_v = 0; ph_err = 0; ph_e2 = 0; ph_wr = 0; ph_wait = 0; ph_idx = 0;
      ph_mask = 0;
      #1 resetn = 0;
      #1;
      chk("rst_hready", 32'(bus.hready_o), 32'd1);
      chk("rst_hresp", 32'(bus.hresp_o), 32'd0);
      chk("rst_hrdata", bus.hrdata_o, 32'd0);
      step(0, 32'h0, 3'd0, 0);
      resetn = 1;
      for (int i = 0; i < MW; i++) xfer(BASE + 32'(4 * i), 3'd2, 1, $urandom);
      drain();
      xfer(BASE + 32'h10, 3'd2, 1, 32'hDEADBEEF);
      xfer(BASE + 32'h10, 3'd2, 0, 32'h0);
      drain();
      chk("wr_rd_b2b", got_rd, 32'hDEADBEEF);
      xfer(BASE + 32'h10, 3'd2, 1, 32'h11223344);
      xfer(BASE + 32'h11, 3'd0, 1, 32'hFFFFAAFF);
      xfer(BASE + 32'h10, 3'd2, 0, 32'h0);
      drain();
      chk("byte_lane", got_rd, 32'h1122AA44);
      xfer(BASE + 32'h12, 3'd1, 1, 32'h5566FFFF);
      xfer(BASE + 32'h10, 3'd2, 0, 32'h0);
      drain();
      chk("half_lane", got_rd, 32'h5566AA44);
      xfer(BASE, 3'd2, 0, 32'h0);
      c0 = cyc;
      for (int i = 1; i < 4; i++) xfer(BASE + 32'(4 * i), 3'd2, 0, 32'h0);
      drain();
      chk("b2b_4_reads_cycles", 32'(cyc - c0), 32'd12);
`ifdef AHB_SRAM_ERR_EN
      for (int k = 0; k < 2; k++) begin
         xfer(k == 0 ? BASE + 32'(MW * 4) : BASE + 32'h2, 3'd2, 0, 32'h0);
         step(0, 32'h0, 3'd0, 0);
         chk("err1_hready", 32'(bus.hready_o), 32'd0);
         chk("err1_hresp", 32'(bus.hresp_o), 32'd1);
         step(0, 32'h0, 3'd0, 0);
         chk("err2_hready", 32'(bus.hready_o), 32'd1);
         chk("err2_hresp", 32'(bus.hresp_o), 32'd1);
         chk("err2_hrdata", bus.hrdata_o, 32'd0);
      end
`else
      xfer(BASE + 32'(MW * 4) + 32'h4, 3'd2, 1, 32'h12345678);
      xfer(BASE + 32'h4, 3'd2, 0, 32'h0);
      drain();
      chk("wrap", got_rd, 32'h12345678);
      chk("wrap_hresp", 32'(bus.hresp_o), 32'd0);
`endif
      xfer(BASE + 32'h10, 3'd2, 1, 32'hCAFEF00D);
      step(0, 32'h0, 3'd0, 0);
      #2 resetn = 0;
      #1;
      ph_v = 0;
      chk("midrst_hready", 32'(bus.hready_o), 32'd1);
      chk("midrst_hresp", 32'(bus.hresp_o), 32'd0);
      chk("midrst_hrdata", bus.hrdata_o, 32'd0);
      step(0, 32'h0, 3'd0, 0);
      resetn = 1;
      xfer(BASE + 32'h10, 3'd2, 0, 32'h0);
      drain();
      chk("midrst_no_commit", got_rd, 32'h5566AA44);
      repeat (500) begin
         ra = ($urandom % 16 == 0) ? $urandom : BASE - 32'd8 + 32'($urandom_range(0, MW * 4 + 15));
         if ($urandom % 8 == 0) step(0, ra, 3'($urandom_range(0, 4)), 1'($urandom));
         else xfer(ra, 3'($urandom_range(0, 4)), 1'($urandom), $urandom);
      end
      drain();
      for (int i = 0; i < MW; i++) xfer(BASE + 32'(4 * i), 3'd2, 0, 32'h0);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
